// File: rtl/cnn_mac_pkg.sv
// Shared width limits, saturation bounds and the rounding constant for the
// convolution MAC pipeline.
package cnn_mac_pkg;

    // Bounds are built in 64-bit signed arithmetic, so every width must leave
    // headroom for one extra sign bit.
    localparam int MAX_ACC_W = 62;

    function automatic logic signed [63:0] sat_max(input int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int n);
        return -(64'sd1 <<< (n - 1));
    endfunction

    // Half an output LSB, added before the shift so that ties round toward +inf.
    function automatic logic signed [63:0] rnd_const(input int shift);
        return (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
    endfunction

    function automatic bit acc_w_ok(input int a_w, input int b_w, input int acc_w);
        return (acc_w >= a_w + b_w + 1) && (acc_w <= MAX_ACC_W);
    endfunction

    function automatic bit out_w_ok(input int out_w, input int acc_w, input int shift);
        return (out_w >= 2) && (out_w <= acc_w) && (shift >= 0) && (shift < acc_w);
    endfunction

endpackage

// File: rtl/cnn_mac_round_sat.sv
// Combinational output conditioning: round half up, arithmetic shift right,
// then saturate to the output width with a clamp flag.
module cnn_mac_round_sat
    import cnn_mac_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val,
    output logic                    o_clamp
);

    localparam logic signed [63:0]   RND64  = rnd_const(SHIFT);
    localparam logic signed [63:0]   OMAX64 = sat_max(OUT_W);
    localparam logic signed [63:0]   OMIN64 = sat_min(OUT_W);
    localparam logic signed [IN_W:0] RND    = RND64[IN_W:0];
    localparam logic signed [IN_W:0] OMAX   = OMAX64[IN_W:0];
    localparam logic signed [IN_W:0] OMIN   = OMIN64[IN_W:0];

    // One guard bit keeps the rounding add from wrapping at the top of range.
    logic signed [IN_W:0] w_rnd;
    logic signed [IN_W:0] w_shf;

    assign w_rnd = $signed({i_val[IN_W-1], i_val}) + RND;
    assign w_shf = w_rnd >>> SHIFT;

    always_comb begin
        o_val   = w_shf[OUT_W-1:0];
        o_clamp = 1'b0;
        if (w_shf > OMAX) begin
            o_val   = OMAX[OUT_W-1:0];
            o_clamp = 1'b1;
        end else if (w_shf < OMIN) begin
            o_val   = OMIN[OUT_W-1:0];
            o_clamp = 1'b1;
        end
    end

endmodule

// File: rtl/cnn_mac_pipe.sv
// Pipelined signed multiply-accumulate for one kernel window per group:
// register inputs, multiply, accumulate onto bias with saturation, round/emit.
module cnn_mac_pipe
    import cnn_mac_pkg::*;
#(
    parameter int A_W   = 14,
    parameter int B_W   = 6,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [A_W-1:0]   in_a,
    input  logic signed [B_W-1:0]   in_b,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic signed [ACC_W-1:0] in_bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat
);

    localparam int P_W = A_W + B_W;

    localparam logic signed [63:0]      ACC_MAX64 = sat_max(ACC_W);
    localparam logic signed [63:0]      ACC_MIN64 = sat_min(ACC_W);
    localparam logic signed [ACC_W-1:0] ACC_MAX   = ACC_MAX64[ACC_W-1:0];
    localparam logic signed [ACC_W-1:0] ACC_MIN   = ACC_MIN64[ACC_W-1:0];

    if (!acc_w_ok(A_W, B_W, ACC_W)) begin : g_bad_acc_w
        $error("cnn_mac_pipe: ACC_W must cover A_W+B_W+1 and stay within MAX_ACC_W");
    end
    if (!out_w_ok(OUT_W, ACC_W, SHIFT)) begin : g_bad_out_w
        $error("cnn_mac_pipe: OUT_W must be <= ACC_W and SHIFT in [0, ACC_W)");
    end

    // Single global enable: the whole pipe freezes while a result is held.
    logic r_run;
    logic w_en;
    logic w_take;

    logic                    r_s1_vld;
    logic signed [A_W-1:0]   r_s1_a;
    logic signed [B_W-1:0]   r_s1_b;
    logic                    r_s1_first;
    logic                    r_s1_last;
    logic signed [ACC_W-1:0] r_s1_bias;

    logic                    r_s2_vld;
    logic signed [P_W-1:0]   r_s2_p;
    logic                    r_s2_first;
    logic                    r_s2_last;
    logic signed [ACC_W-1:0] r_s2_bias;

    logic                    r_s3_vld;
    logic                    r_s3_last;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_gsat;

    logic                    r_out_vld;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_out_sat;

    logic signed [P_W-1:0]   w_a_ext;
    logic signed [P_W-1:0]   w_b_ext;
    logic signed [ACC_W-1:0] w_p_ext;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic                    w_acc_clamp;
    logic                    w_emit;
    logic signed [OUT_W-1:0] w_rs_val;
    logic                    w_rs_clamp;

    assign w_en      = !r_out_vld || out_ready;
    assign in_ready  = r_run && w_en;
    assign w_take    = in_valid && in_ready;
    assign out_valid = r_out_vld;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_run      <= 1'b0;
            r_s1_vld   <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_bias  <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_en) begin
                r_s1_vld <= w_take;
                if (w_take) begin
                    r_s1_a     <= in_a;
                    r_s1_b     <= in_b;
                    r_s1_first <= in_first;
                    r_s1_last  <= in_last;
                    r_s1_bias  <= in_bias;
                end
            end
        end
    end

    // Operands are widened to the full product width before multiplying.
    assign w_a_ext = P_W'(r_s1_a);
    assign w_b_ext = P_W'(r_s1_b);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_s2_vld   <= 1'b0;
            r_s2_p     <= '0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_bias  <= '0;
        end else if (w_en) begin
            r_s2_vld   <= r_s1_vld;
            r_s2_p     <= w_a_ext * w_b_ext;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_bias  <= r_s1_bias;
        end
    end

    assign w_p_ext = ACC_W'(r_s2_p);
    assign w_base  = r_s2_first ? r_s2_bias : r_acc;
    assign w_sum   = (ACC_W+1)'(w_base) + (ACC_W+1)'(w_p_ext);

    // Differing top two bits of the widened sum means the ACC_W range overflowed.
    always_comb begin
        w_acc_nxt   = w_sum[ACC_W-1:0];
        w_acc_clamp = 1'b0;
        if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
            w_acc_clamp = 1'b1;
            w_acc_nxt   = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_s3_vld  <= 1'b0;
            r_s3_last <= 1'b0;
            r_acc     <= '0;
            r_gsat    <= 1'b0;
        end else if (w_en) begin
            r_s3_vld  <= r_s2_vld;
            r_s3_last <= r_s2_last;
            if (r_s2_vld) begin
                r_acc  <= w_acc_nxt;
                r_gsat <= (r_s2_first ? 1'b0 : r_gsat) | w_acc_clamp;
            end
        end
    end

    cnn_mac_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .i_val   (r_acc),
        .o_val   (w_rs_val),
        .o_clamp (w_rs_clamp)
    );

    // S4 reads r_acc and r_gsat on the same edge the next group's first
    // element may overwrite them, so groups need no bubble between them.
    assign w_emit = r_s3_vld && r_s3_last;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (w_en) begin
            r_out_vld <= w_emit;
            if (w_emit) begin
                r_out_data <= w_rs_val;
                r_out_sat  <= r_gsat | w_rs_clamp;
            end
        end
    end

endmodule
